pipeline_controller: RTL

PIPELINE_CONTROLLER -- requirements
Module: pipeline_controller

---
 rtl/pipeline_controller_pkg.sv | 83 ++++++++
 rtl/cond_unit.sv | 27 ++
 rtl/pipeline_controller.sv | 166 ++++++++++++++++
 3 files changed

// File: rtl/pipeline_controller_pkg.sv
// rtl/pipeline_controller_pkg.sv - shared encodings for the pipelined ARM control unit
package pipeline_controller_pkg;

  localparam logic [1:0] OP_DP  = 2'b00;
  localparam logic [1:0] OP_MEM = 2'b01;
  localparam logic [1:0] OP_BR  = 2'b10;

  localparam logic [3:0] CMD_AND = 4'b0000;
  localparam logic [3:0] CMD_EOR = 4'b0001;
  localparam logic [3:0] CMD_SUB = 4'b0010;
  localparam logic [3:0] CMD_ADD = 4'b0100;
  localparam logic [3:0] CMD_CMP = 4'b1010;
  localparam logic [3:0] CMD_ORR = 4'b1100;
  localparam logic [3:0] CMD_MOV = 4'b1101;

  localparam logic [3:0] COND_EQ = 4'b0000;
  localparam logic [3:0] COND_NE = 4'b0001;
  localparam logic [3:0] COND_CS = 4'b0010;
  localparam logic [3:0] COND_CC = 4'b0011;
  localparam logic [3:0] COND_MI = 4'b0100;
  localparam logic [3:0] COND_PL = 4'b0101;
  localparam logic [3:0] COND_VS = 4'b0110;
  localparam logic [3:0] COND_VC = 4'b0111;
  localparam logic [3:0] COND_HI = 4'b1000;
  localparam logic [3:0] COND_LS = 4'b1001;
  localparam logic [3:0] COND_GE = 4'b1010;
  localparam logic [3:0] COND_LT = 4'b1011;
  localparam logic [3:0] COND_GT = 4'b1100;
  localparam logic [3:0] COND_LE = 4'b1101;
  localparam logic [3:0] COND_AL = 4'b1110;

  // FlagWrite bit 1 covers N/Z, bit 0 covers C/V
  localparam logic [1:0] FW_NONE = 2'b00;
  localparam logic [1:0] FW_NZ   = 2'b10;
  localparam logic [1:0] FW_ALL  = 2'b11;

  typedef enum logic [2:0] {
    ALU_ADD = 3'd0,
    ALU_SUB = 3'd1,
    ALU_AND = 3'd2,
    ALU_ORR = 3'd3,
    ALU_EOR = 3'd4,
    ALU_MOV = 3'd5
  } alu_ctrl_e;

  typedef struct packed {
    logic [3:0] cond;
    logic [1:0] flag_write;
    alu_ctrl_e  alu_ctrl;
    logic       alu_src;
    logic       reg_write;
    logic       mem_write;
    logic       mem_to_reg;
    logic       branch;
    logic       pc_src;
  } ctrl_de_t;

  function automatic logic cond_holds(input logic [3:0] cond, input logic [3:0] flags);
    logic n, z, c, v, res;
    {n, z, c, v} = flags;
    res = 1'b0;
    case (cond)
      COND_EQ: res = z;
      COND_NE: res = ~z;
      COND_CS: res = c;
      COND_CC: res = ~c;
      COND_MI: res = n;
      COND_PL: res = ~n;
      COND_VS: res = v;
      COND_VC: res = ~v;
      COND_HI: res = c & ~z;
      COND_LS: res = ~c | z;
      COND_GE: res = (n == v);
      COND_LT: res = (n != v);
      COND_GT: res = ~z & (n == v);
      COND_LE: res = z | (n != v);
      COND_AL: res = 1'b1;
      default: res = 1'b0;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/cond_unit.sv
// rtl/cond_unit.sv - Execute-stage condition check and NZCV flags register
module cond_unit
  import pipeline_controller_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] cond_e,
  input  logic [1:0] flag_write_e,
  input  logic [3:0] alu_flags,
  output logic       cond_ex_e
);

  logic [3:0] flags_q;

  assign cond_ex_e = cond_holds(cond_e, flags_q);

  // A failed condition must not let the instruction update any flag group
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      flags_q <= 4'b0000;
    end else begin
      if (flag_write_e[1] & cond_ex_e) flags_q[3:2] <= alu_flags[3:2];
      if (flag_write_e[0] & cond_ex_e) flags_q[1:0] <= alu_flags[1:0];
    end
  end

endmodule

// File: rtl/pipeline_controller.sv
// rtl/pipeline_controller.sv - decoder, control pipeline and hazard unit for a 5-stage ARM core
module pipeline_controller
  import pipeline_controller_pkg::*;
#(
  parameter int ALUCTRL_W = 6
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [31:0]          InstrD,
  input  logic [3:0]           ALUFlags,
  input  logic                 Match_1E_M,
  input  logic                 Match_1E_W,
  input  logic                 Match_2E_M,
  input  logic                 Match_2E_W,
  input  logic                 Match12D_E,
  output logic [1:0]           RegSrcD,
  output logic [1:0]           ImmSrcD,
  output logic                 ALUSrcE,
  output logic [ALUCTRL_W-1:0] ALUControlE,
  output logic                 BranchTakenE,
  output logic                 MemWriteM,
  output logic                 PCSrcW,
  output logic                 MemtoRegW,
  output logic                 RegWriteW,
  output logic                 StallF,
  output logic                 StallD,
  output logic                 FlushD,
  output logic                 FlushE,
  output logic [1:0]           ForwardAE,
  output logic [1:0]           ForwardBE
);

  ctrl_de_t ctrl_d;
  ctrl_de_t de_q;
  logic     cond_ex_e;
  logic     reg_write_m, mem_to_reg_m, pc_src_m;
  logic     ldr_stall, pc_wr_pend;
  logic     unused_instr;

  assign unused_instr = ^{InstrD[19:16], InstrD[11:0]};

  always_comb begin
    RegSrcD            = 2'b00;
    ImmSrcD            = 2'b00;
    ctrl_d.cond        = InstrD[31:28];
    ctrl_d.flag_write  = FW_NONE;
    ctrl_d.alu_ctrl    = ALU_ADD;
    ctrl_d.alu_src     = 1'b0;
    ctrl_d.reg_write   = 1'b0;
    ctrl_d.mem_write   = 1'b0;
    ctrl_d.mem_to_reg  = 1'b0;
    ctrl_d.branch      = 1'b0;
    ctrl_d.pc_src      = 1'b0;
    case (InstrD[27:26])
      OP_DP: begin
        ctrl_d.alu_src    = InstrD[25];
        ctrl_d.reg_write  = 1'b1;
        ctrl_d.flag_write = InstrD[20] ? FW_NZ : FW_NONE;
        case (InstrD[24:21])
          CMD_AND: ctrl_d.alu_ctrl = ALU_AND;
          CMD_EOR: ctrl_d.alu_ctrl = ALU_EOR;
          CMD_ORR: ctrl_d.alu_ctrl = ALU_ORR;
          CMD_MOV: ctrl_d.alu_ctrl = ALU_MOV;
          CMD_ADD: begin
            ctrl_d.alu_ctrl = ALU_ADD;
            if (InstrD[20]) ctrl_d.flag_write = FW_ALL;
          end
          CMD_SUB: begin
            ctrl_d.alu_ctrl = ALU_SUB;
            if (InstrD[20]) ctrl_d.flag_write = FW_ALL;
          end
          CMD_CMP: begin
            ctrl_d.alu_ctrl   = ALU_SUB;
            ctrl_d.reg_write  = 1'b0;
            ctrl_d.flag_write = FW_ALL;
          end
          default: begin
            ctrl_d.reg_write  = 1'b0;
            ctrl_d.flag_write = FW_NONE;
          end
        endcase
      end
      OP_MEM: begin
        ctrl_d.alu_src = 1'b1;
        ImmSrcD        = 2'b01;
        if (InstrD[20]) begin
          ctrl_d.mem_to_reg = 1'b1;
          ctrl_d.reg_write  = 1'b1;
        end else begin
          ctrl_d.mem_write = 1'b1;
          RegSrcD[1]       = 1'b1;
        end
      end
      OP_BR: begin
        ctrl_d.branch  = 1'b1;
        ctrl_d.alu_src = 1'b1;
        ImmSrcD        = 2'b10;
        RegSrcD[0]     = 1'b1;
      end
      default: ;
    endcase
    ctrl_d.pc_src = ctrl_d.reg_write & (InstrD[15:12] == 4'hF) & ~ctrl_d.branch;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      de_q <= '0;
    end else if (FlushE) begin
      de_q <= '0;
    end else begin
      de_q <= ctrl_d;
    end
  end

  cond_unit u_cond_unit (
    .clk          (clk),
    .reset        (reset),
    .cond_e       (de_q.cond),
    .flag_write_e (de_q.flag_write),
    .alu_flags    (ALUFlags),
    .cond_ex_e    (cond_ex_e)
  );

  assign ALUSrcE      = de_q.alu_src;
  assign ALUControlE  = ALUCTRL_W'(de_q.alu_ctrl);
  assign BranchTakenE = de_q.branch & cond_ex_e;

  // Architectural side effects are squashed here when the condition fails
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      reg_write_m  <= 1'b0;
      MemWriteM    <= 1'b0;
      mem_to_reg_m <= 1'b0;
      pc_src_m     <= 1'b0;
      RegWriteW    <= 1'b0;
      MemtoRegW    <= 1'b0;
      PCSrcW       <= 1'b0;
    end else begin
      reg_write_m  <= de_q.reg_write & cond_ex_e;
      MemWriteM    <= de_q.mem_write & cond_ex_e;
      mem_to_reg_m <= de_q.mem_to_reg;
      pc_src_m     <= de_q.pc_src & cond_ex_e;
      RegWriteW    <= reg_write_m;
      MemtoRegW    <= mem_to_reg_m;
      PCSrcW       <= pc_src_m;
    end
  end

  always_comb begin
    ForwardAE = 2'b00;
    ForwardBE = 2'b00;
    if (Match_1E_M & reg_write_m)    ForwardAE = 2'b10;
    else if (Match_1E_W & RegWriteW) ForwardAE = 2'b01;
    if (Match_2E_M & reg_write_m)    ForwardBE = 2'b10;
    else if (Match_2E_W & RegWriteW) ForwardBE = 2'b01;
  end

  // PC writes in flight use the unconditioned E term so fetch never races a possible PC update
  assign ldr_stall  = Match12D_E & de_q.mem_to_reg;
  assign pc_wr_pend = ctrl_d.pc_src | de_q.pc_src | pc_src_m;
  assign StallF     = ldr_stall | pc_wr_pend;
  assign StallD     = ldr_stall;
  assign FlushD     = pc_wr_pend | PCSrcW | BranchTakenE;
  assign FlushE     = ldr_stall | BranchTakenE;

endmodule
